// File: rtl/dma_pkg.sv
// Shared DMA types: descriptor, engine status/error records and scheduler states.
package dma_pkg;

    localparam int unsigned DMA_ADDR_W = 32;
    localparam int unsigned DMA_LEN_W  = 16;

    typedef enum logic [1:0] {
        ERR_SRC_NONE = 2'd0,
        ERR_SRC_RD   = 2'd1,
        ERR_SRC_WR   = 2'd2
    } e_dma_err_src_t;

    typedef struct packed {
        logic [DMA_ADDR_W-1:0] src_addr;
        logic [DMA_ADDR_W-1:0] dst_addr;
        logic [DMA_LEN_W-1:0]  num_bytes;
    } s_dma_desc_t;

    typedef struct packed {
        logic done;
        logic active;
        logic error;
    } s_dma_status_t;

    typedef struct packed {
        logic                  valid;
        e_dma_err_src_t        src;
        logic [DMA_ADDR_W-1:0] addr;
    } s_dma_error_t;

    typedef enum logic [1:0] {
        ARB     = 2'd0,
        LAUNCH  = 2'd1,
        RELEASE = 2'd2,
        RESP    = 2'd3
    } dma_sched_st_t;

endpackage

// File: rtl/dma_chan_sched_if.sv
// Requester-side bundle: per-channel descriptor handshake plus completion report.
interface dma_chan_sched_if
    import dma_pkg::*;
#(
    parameter int unsigned NUM_CH = 4
) ();

    logic        [NUM_CH-1:0] ch_req_valid_i;
    logic        [NUM_CH-1:0] ch_req_ready_o;
    s_dma_desc_t [NUM_CH-1:0] ch_desc_i;
    logic        [NUM_CH-1:0] ch_done_o;
    s_dma_error_t             ch_err_o;

    // Requesters drive descriptors and observe accept/completion.
    modport master (
        output ch_req_valid_i,
        output ch_desc_i,
        input  ch_req_ready_o,
        input  ch_done_o,
        input  ch_err_o
    );

    // Scheduler accepts descriptors and reports completion.
    modport slave (
        input  ch_req_valid_i,
        input  ch_desc_i,
        output ch_req_ready_o,
        output ch_done_o,
        output ch_err_o
    );

endinterface

// File: rtl/dma_rr_arbiter.sv
// Combinational round-robin pick: first requester at or above i_ptr, wrapping.
module dma_rr_arbiter #(
    parameter  int unsigned NUM_CH = 4,
    localparam int unsigned CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [CH_W-1:0]   i_ptr,
    output logic [NUM_CH-1:0] o_grant,
    output logic [CH_W-1:0]   o_idx,
    output logic              o_any
);

    localparam int unsigned CW1 = CH_W + 1;

    logic [CW1-1:0] w_cand;
    logic           w_found;

    // Scan NUM_CH slots starting at the pointer; the first hit wins.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int unsigned off = 0; off < NUM_CH; off++) begin
            w_cand = {1'b0, i_ptr} + CW1'(off);
            if (w_cand >= CW1'(NUM_CH)) begin
                w_cand = w_cand - CW1'(NUM_CH);
            end
            if (!w_found && i_req[w_cand[CH_W-1:0]]) begin
                w_found = 1'b1;
                o_idx   = w_cand[CH_W-1:0];
            end
        end
        if (w_found) begin
            o_grant[o_idx] = 1'b1;
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/dma_chan_sched.sv
// Round-robin front end that serialises channel descriptors onto one DMA engine.
module dma_chan_sched
    import dma_pkg::*;
#(
    parameter  int unsigned NUM_CH = 4,
    localparam int unsigned CH_W   = $clog2(NUM_CH)
) (
    input  logic            clk,
    input  logic            rst,
    dma_chan_sched_if.slave ch_if,
    output logic            busy_o,
    output logic [CH_W-1:0] grant_id_o,
    output logic            dma_go_o,
    output s_dma_desc_t     dma_desc_o,
    input  s_dma_status_t   dma_stats_i,
    input  s_dma_error_t    dma_error_i
);

    dma_sched_st_t     r_state;
    logic [CH_W-1:0]   r_rr_ptr;
    logic              r_err_seen;
    s_dma_error_t      r_err_rec;
    logic [NUM_CH-1:0] r_done;
    logic              r_busy;
    logic [CH_W-1:0]   r_grant;
    logic              r_go;
    s_dma_desc_t       r_desc;

    logic [NUM_CH-1:0] w_grant;
    logic [CH_W-1:0]   w_idx;
    logic              w_any;
    logic [CH_W-1:0]   w_next_ptr;
    s_dma_desc_t       w_sel_desc;
    logic [NUM_CH-1:0] w_owner_oh;

    dma_rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .i_req   (ch_if.ch_req_valid_i),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_sel_desc = ch_if.ch_desc_i[w_idx];
    assign w_next_ptr = (w_idx == CH_W'(NUM_CH - 1)) ? '0 : w_idx + CH_W'(1);
    assign w_owner_oh = NUM_CH'(1) << r_grant;

    // Accept is same-cycle; held off during reset so no handshake is lost.
    assign ch_if.ch_req_ready_o = (r_state == ARB && !rst) ? w_grant : '0;
    assign ch_if.ch_done_o      = r_done;
    assign ch_if.ch_err_o       = r_err_rec;

    assign busy_o     = r_busy;
    assign grant_id_o = r_grant;
    assign dma_go_o   = r_go;
    assign dma_desc_o = r_desc;

    // Job sequencer: arbitrate, launch engine, wait for it to idle, report.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ARB;
            r_rr_ptr   <= '0;
            r_err_seen <= 1'b0;
            r_err_rec  <= '0;
            r_done     <= '0;
            r_busy     <= 1'b0;
            r_grant    <= '0;
            r_go       <= 1'b0;
            r_desc     <= '0;
        end else begin
            r_done <= '0;
            case (r_state)
                ARB: begin
                    if (w_any) begin
                        r_grant    <= w_idx;
                        r_desc     <= w_sel_desc;
                        r_rr_ptr   <= w_next_ptr;
                        r_busy     <= 1'b1;
                        r_err_rec  <= '0;
                        r_err_seen <= 1'b0;
                        if (w_sel_desc.num_bytes == '0) begin
                            r_state <= RESP;
                            r_done  <= w_grant;
                        end else begin
                            r_state <= LAUNCH;
                            r_go    <= 1'b1;
                        end
                    end
                end
                LAUNCH: begin
                    if (dma_stats_i.error) begin
                        r_err_seen <= 1'b1;
                    end
                    // The engine error record is sticky; only trust it if this job pulsed error.
                    if (dma_stats_i.done) begin
                        r_err_rec <= (r_err_seen || dma_stats_i.error) ? dma_error_i : '0;
                        r_go      <= 1'b0;
                        r_state   <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!dma_stats_i.done && !dma_stats_i.active) begin
                        r_state <= RESP;
                        r_done  <= w_owner_oh;
                    end
                end
                RESP: begin
                    r_err_seen <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= ARB;
                end
                default: begin
                    r_state <= ARB;
                end
            endcase
        end
    end

    // A requester must hold valid until it is accepted.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_hold
        a_valid_hold : assert property (
            @(posedge clk) disable iff (rst)
            (ch_if.ch_req_valid_i[g] && !ch_if.ch_req_ready_o[g]) |=> ch_if.ch_req_valid_i[g]
        );
    end

endmodule

// File: tb/tb_dma_chan_sched.sv
// Directed bench for dma_chan_sched with a small cycle-level engine model.
module tb_dma_chan_sched;
    import dma_pkg::*;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CH_W   = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            busy;
    logic [CH_W-1:0] grant;
    logic            go;
    s_dma_desc_t     desc_o;
    s_dma_status_t   stats;
    s_dma_error_t    eng_err;

    always #5 clk = ~clk;

    dma_chan_sched_if #(.NUM_CH(NUM_CH)) u_ch_if ();

    dma_chan_sched #(
        .NUM_CH (NUM_CH)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .ch_if       (u_ch_if.slave),
        .busy_o      (busy),
        .grant_id_o  (grant),
        .dma_go_o    (go),
        .dma_desc_o  (desc_o),
        .dma_stats_i (stats),
        .dma_error_i (eng_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Bench-side bookkeeping
    int           cyc;
    int           rearm     [NUM_CH];
    int           done_cnt  [NUM_CH];
    int           ready_cyc [NUM_CH];
    int           last_acc  [NUM_CH];
    int           last_done [NUM_CH];
    int           acc_q[$];
    int           done_q[$];
    int           go_cyc;
    int           multi_ready;
    s_dma_error_t last_err;

    // Engine model state: 0 idle, 1 run, 2 done
    int           e_st;
    int           e_cnt;
    int           e_run_len;
    int           e_hold;
    int           e_hold_cnt;
    int           e_err_at;
    int           e_done_cyc;
    s_dma_error_t e_err_inj;

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic s_dma_desc_t mk_desc(input logic [31:0] src, input logic [31:0] dst,
                                            input logic [15:0] nb);
        s_dma_desc_t d;
        d.src_addr  = src;
        d.dst_addr  = dst;
        d.num_bytes = nb;
        return d;
    endfunction

    task automatic clr();
        acc_q.delete();
        done_q.delete();
        for (int i = 0; i < NUM_CH; i++) begin
            done_cnt[i]  = 0;
            ready_cyc[i] = 0;
            last_acc[i]  = -1;
            last_done[i] = -1;
            rearm[i]     = 0;
        end
        go_cyc      = 0;
        multi_ready = 0;
        last_err    = '0;
        e_done_cyc  = -1;
    endtask

    // One clock: record handshake, advance engine/requesters, sample outputs at negedge.
    task automatic step();
        logic [NUM_CH-1:0] hs;
        logic              go_k;
        logic              rst_k;
        #1;
        hs    = u_ch_if.ch_req_valid_i & u_ch_if.ch_req_ready_o;
        go_k  = go;
        rst_k = rst;
        if ($countones(u_ch_if.ch_req_ready_o) > 1) multi_ready++;
        for (int i = 0; i < NUM_CH; i++) begin
            if (u_ch_if.ch_req_ready_o[i]) ready_cyc[i]++;
            if (hs[i]) begin
                acc_q.push_back(i);
                last_acc[i] = cyc;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rst_k) begin
            e_st    = 0;
            stats   = '0;
            eng_err = '0;
        end else begin
            stats.error = 1'b0;
            case (e_st)
                0: if (go_k) begin e_st = 1; e_cnt = e_run_len; end
                1: begin
                    if (e_cnt == 1) begin
                        e_st       = 2;
                        e_hold_cnt = e_hold;
                        e_done_cyc = cyc;
                    end else begin
                        e_cnt--;
                    end
                end
                default: begin
                    if (!go_k) begin
                        if (e_hold_cnt > 0) e_hold_cnt--;
                        else e_st = 0;
                    end
                end
            endcase
            if (e_st == 1 && e_err_at > 0 && e_cnt == e_err_at) begin
                stats.error = 1'b1;
                eng_err     = e_err_inj;
            end
            stats.active = (e_st == 1);
            stats.done   = (e_st == 2);
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (hs[i]) begin
                if (rearm[i] > 0) rearm[i]--;
                else u_ch_if.ch_req_valid_i[i] = 1'b0;
            end
        end
        @(negedge clk);
        if (go) go_cyc++;
        for (int i = 0; i < NUM_CH; i++) begin
            if (u_ch_if.ch_done_o[i]) begin
                done_cnt[i]++;
                done_q.push_back(i);
                last_done[i] = cyc;
                last_err     = u_ch_if.ch_err_o;
            end
        end
    endtask

    task automatic wait_done(input int ch, input int budget, input string tag);
        int start;
        bit ok;
        start = done_cnt[ch];
        ok    = 1'b0;
        for (int n = 0; n < budget; n++) begin
            step();
            if (done_cnt[ch] != start) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_eq(tag, 128'(0), 128'(1));
    endtask

    task automatic wait_idle(input int budget, input string tag);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            step();
            if (!busy && u_ch_if.ch_req_valid_i == '0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_eq(tag, 128'(0), 128'(1));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        s_dma_error_t exp_err;
        bit           seen_go;

        rst                      = 1'b1;
        u_ch_if.ch_req_valid_i   = '0;
        u_ch_if.ch_desc_i        = '0;
        stats                    = '0;
        eng_err                  = '0;
        cyc                      = 0;
        e_st                     = 0;
        e_cnt                    = 0;
        e_run_len                = 5;
        e_hold                   = 0;
        e_hold_cnt               = 0;
        e_err_at                 = 0;
        e_err_inj                = '0;
        clr();
        @(negedge clk);
        step();
        step();

        // Reset state
        check_eq("rst_busy",  128'(busy), 128'(0));
        check_eq("rst_go",    128'(go), 128'(0));
        check_eq("rst_grant", 128'(grant), 128'(0));
        check_eq("rst_done",  128'(u_ch_if.ch_done_o), 128'(0));
        check_eq("rst_ready", 128'(u_ch_if.ch_req_ready_o), 128'(0));
        check_eq("rst_desc",  128'(desc_o), 128'(0));
        check_eq("rst_err",   128'(u_ch_if.ch_err_o), 128'(0));
        rst = 1'b0;
        step();

        // Single ch1 job, 5 RUN cycles
        clr();
        u_ch_if.ch_desc_i[1]      = mk_desc(32'h100, 32'h200, 16'd64);
        u_ch_if.ch_req_valid_i[1] = 1'b1;
        wait_done(1, 60, "single_timeout");
        check_eq("single_ready_cycles", 128'(ready_cyc[1]), 128'(1));
        check_eq("single_go_cycles",    128'(go_cyc), 128'(7));
        check_eq("single_latency",      128'(last_done[1] - last_acc[1]), 128'(10));
        check_eq("single_done_after_eng", 128'(last_done[1] - e_done_cyc), 128'(3));
        check_eq("single_err",          128'(last_err), 128'(0));
        check_eq("single_desc",         128'(desc_o), 128'(mk_desc(32'h100, 32'h200, 16'd64)));
        check_eq("single_grant",        128'(grant), 128'(1));
        check_eq("single_done_cnt",     128'(done_cnt[1]), 128'(1));
        step();
        check_eq("single_idle",         128'(busy), 128'(0));

        // Zero-byte job on ch2
        clr();
        u_ch_if.ch_desc_i[2]      = mk_desc(32'h300, 32'h400, 16'd0);
        u_ch_if.ch_req_valid_i[2] = 1'b1;
        wait_done(2, 20, "zero_timeout");
        check_eq("zero_ready_cycles", 128'(ready_cyc[2]), 128'(1));
        check_eq("zero_latency",      128'(last_done[2] - last_acc[2]), 128'(1));
        check_eq("zero_go_cycles",    128'(go_cyc), 128'(0));
        check_eq("zero_err",          128'(last_err), 128'(0));
        step();

        // ch3 job with an engine error pulse
        clr();
        e_err_at       = 3;
        e_err_inj      = '0;
        e_err_inj.valid = 1'b1;
        e_err_inj.src  = ERR_SRC_WR;
        e_err_inj.addr = 32'h1000;
        exp_err        = '0;
        exp_err.valid  = 1'b1;
        exp_err.src    = ERR_SRC_WR;
        exp_err.addr   = 32'h1000;
        u_ch_if.ch_desc_i[3]      = mk_desc(32'h500, 32'h600, 16'd128);
        u_ch_if.ch_req_valid_i[3] = 1'b1;
        wait_done(3, 60, "err_timeout");
        check_eq("err_report",   128'(last_err), 128'(exp_err));
        check_eq("err_done_cnt", 128'(done_cnt[3]), 128'(1));
        e_err_at = 0;
        step();

        // Following ch0 job sees only a stale engine error
        clr();
        u_ch_if.ch_desc_i[0]      = mk_desc(32'h700, 32'h800, 16'd32);
        u_ch_if.ch_req_valid_i[0] = 1'b1;
        wait_done(0, 60, "stale_timeout");
        check_eq("stale_err_valid", 128'(last_err.valid), 128'(0));
        check_eq("stale_err",       128'(last_err), 128'(0));
        step();

        // Engine holds done for 3 cycles after go drops
        clr();
        e_hold = 2;
        u_ch_if.ch_req_valid_i[1] = 1'b1;
        wait_done(1, 60, "hold_timeout");
        check_eq("hold_latency",        128'(last_done[1] - last_acc[1]), 128'(12));
        check_eq("hold_done_after_eng", 128'(last_done[1] - e_done_cyc), 128'(5));
        check_eq("hold_go_cycles",      128'(go_cyc), 128'(7));
        e_hold = 0;
        step();

        // All channels request twice, rotation from pointer 0
        do_reset();
        clr();
        e_run_len = 1;
        for (int i = 0; i < NUM_CH; i++) begin
            u_ch_if.ch_desc_i[i]      = mk_desc(32'(i) << 8, 32'(i) << 12, 16'd16);
            rearm[i]                  = 1;
            u_ch_if.ch_req_valid_i[i] = 1'b1;
        end
        wait_idle(300, "rr_timeout");
        check_eq("rr_accepts", 128'(acc_q.size()), 128'(8));
        for (int k = 0; k < 8; k++) begin
            if (k < acc_q.size()) check_eq($sformatf("rr_order_%0d", k), 128'(acc_q[k]), 128'(k % 4));
            if (k < done_q.size()) check_eq($sformatf("rr_done_order_%0d", k), 128'(done_q[k]), 128'(k % 4));
        end
        for (int i = 0; i < NUM_CH; i++) begin
            check_eq($sformatf("rr_done_cnt_%0d", i), 128'(done_cnt[i]), 128'(2));
        end
        check_eq("rr_onehot_ready", 128'(multi_ready), 128'(0));

        // Reset while in LAUNCH abandons the job
        clr();
        e_run_len = 5;
        u_ch_if.ch_desc_i[1]      = mk_desc(32'h900, 32'ha00, 16'd64);
        u_ch_if.ch_req_valid_i[1] = 1'b1;
        seen_go = 1'b0;
        for (int n = 0; n < 10; n++) begin
            step();
            if (go) begin
                seen_go = 1'b1;
                break;
            end
        end
        check_eq("mid_go_seen", 128'(seen_go), 128'(1));
        u_ch_if.ch_req_valid_i[2] = 1'b1;
        rst = 1'b1;
        step();
        check_eq("mid_rst_go",    128'(go), 128'(0));
        check_eq("mid_rst_busy",  128'(busy), 128'(0));
        check_eq("mid_rst_grant", 128'(grant), 128'(0));
        check_eq("mid_rst_ready", 128'(u_ch_if.ch_req_ready_o), 128'(0));
        check_eq("mid_rst_done",  128'(u_ch_if.ch_done_o), 128'(0));
        check_eq("mid_rst_desc",  128'(desc_o), 128'(0));
        rst = 1'b0;
        step();
        check_eq("mid_reaccept_cnt", 128'(acc_q.size()), 128'(2));
        if (acc_q.size() == 2) check_eq("mid_reaccept_ch", 128'(acc_q[1]), 128'(2));
        check_eq("mid_grant", 128'(grant), 128'(2));
        wait_done(2, 60, "mid_timeout");
        check_eq("mid_no_done_ch1", 128'(done_cnt[1]), 128'(0));
        check_eq("mid_done_ch2",    128'(done_cnt[2]), 128'(1));
        step();
        check_eq("mid_idle", 128'(busy), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
